switch_logic_unit: RTL and testbench
====================================

Name: switch_logic_unit

Overview:
- Parametrised, registered successor to the board-level switch/LED boolean demo.
- Each of NUM_SW toggle switches is synchronised and debounced.
- The debounced switches are split into equal groups; one runtime-selectable boolean reduction is applied per group and driven to a green LED.
- A change pulse and a wrap-around change counter report debounced switch activity.
- Sits between the DE2 top level (SWITCH_I/LED ports) and the LEDs.

Parameters:
- NUM_SW, 16, number of switch inputs; must be a multiple of GROUP_W.
- GROUP_W, 4, switches per reduction group; NUM_GRP = NUM_SW/GROUP_W.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a switch change (10 ms at 50 MHz); minimum 2.
- CNT_W, 8, width of the change counter.

Ports:
- CLOCK_50_I  input  1  system clock, 50 MHz
- RESETN_I  input  1  asynchronous active-low reset
- SWITCH_I  input  NUM_SW  raw, asynchronous toggle switches
- MODE_I  input  3  reduction mode to load
- MODE_LOAD_I  input  1  mode register loads MODE_I on a clock edge while high
- LED_RED_O  output  NUM_SW  debounced switch state
- LED_GREEN_O  output  NUM_GRP  per-group reduction result (bit g uses switches [g*GROUP_W +: GROUP_W])
- CHANGE_O  output  1  one-cycle pulse: debounced state changed
- CHANGE_CNT_O  output  CNT_W  count of debounce-change events

Behaviour:
- Reset (RESETN_I low, asynchronous) clears all state: sync flops 0, debounce counters 0, stable state 0, mode 0, LED_RED_O 0, LED_GREEN_O 0, CHANGE_O 0, CHANGE_CNT_O 0.
- Sync: each switch passes through a 2-flop synchroniser; sync[i] lags SWITCH_I[i] by 2 edges.
- Debounce, per bit:
  - If sync[i] == stable[i], cnt[i] is set to 0.
  - Otherwise cnt[i] increments.
  - At the edge where sync[i] != stable[i] and cnt[i] == DEBOUNCE_CYCLES-1, stable[i] takes sync[i] and cnt[i] is set to 0.
  - A pulse shorter than DEBOUNCE_CYCLES cycles after sync is never accepted.
  - Any return to stable[i] restarts the count.
- LED_RED_O = stable (registered, no extra latency).
- A change held on SWITCH_I appears on LED_RED_O DEBOUNCE_CYCLES+2 edges after it is first sampled.
- Mode register: loads MODE_I at any edge with MODE_LOAD_I=1; otherwise it holds.
- Reductions over each group's stable bits, selected by mode:
  - 0: AND
  - 1: OR
  - 2: XOR
  - 3: NAND
  - 4: NOR
  - 5: XNOR
  - 6: MAJORITY (popcount > GROUP_W/2, strictly greater; ties give 0)
  - 7: reserved, drives all 0
- LED_GREEN_O is registered from the current stable and mode, so it lags a stable change or mode load by 1 edge.
- CHANGE_O is registered. It is 1 for exactly the cycle LED_GREEN_O first reflects a new stable value, i.e. one edge after any stable bit flips.
- Simultaneous flips of several bits in one cycle produce a single pulse.
- A mode load alone does not pulse CHANGE_O.
- CHANGE_CNT_O increments by 1 with every CHANGE_O pulse and wraps from 2^CNT_W-1 to 0.
- Reset mid-debounce discards the partial count. After release, switches already high need the full DEBOUNCE_CYCLES+2 latency to appear.
- Steady switches never produce CHANGE_O.

Optional Feature:
- Macro: SLU_DEBOUNCE_BYPASS_EN.
- Defined: debounce counters are not built; stable = sync every cycle. SWITCH_I-to-LED_RED_O latency is 3 edges, and every synced transition (including glitches lasting at least one sampled cycle) pulses CHANGE_O.
- Undefined: full debounce as specified. Port list is identical in both builds.

Test Plan (DEBOUNCE_CYCLES=4, defaults otherwise):
- Assert RESETN_I low mid-cycle with SWITCH_I=16'hFFFF -> all outputs 0 immediately. After release, LED_RED_O=16'hFFFF exactly 6 edges later, CHANGE_CNT_O=1.
- SWITCH_I[0] high for 3 cycles, then low -> LED_RED_O stays 16'h0000, CHANGE_O never asserts, CHANGE_CNT_O stays 0.
- Mode 0 (AND), SWITCH_I 16'h0000 -> 16'h000F held -> LED_RED_O=16'h000F at edge 6, LED_GREEN_O=4'b0001 and CHANGE_O=1 at edge 7, CHANGE_CNT_O=1.
- With 16'h000F stable, pulse MODE_LOAD_I with MODE_I=3 (NAND) -> LED_GREEN_O=4'b1110 two edges after the load edge, no CHANGE_O.
- Mode 6 (MAJORITY), SWITCH_I=16'h7310 -> LED_GREEN_O=4'b1000 (0, 1 and 2 ones give 0; 3 ones give 1). Mode 7 -> 4'b0000.
- Toggle SWITCH_I[5] slowly 257 times -> 257 CHANGE_O pulses, CHANGE_CNT_O=1 (wrap). Repeat with SLU_DEBOUNCE_BYPASS_EN defined: a 1-cycle glitch produces a CHANGE_O pulse, and latency is 3 edges.

Source files
------------

// File: rtl/switch_logic_unit.sv
// Switch front end: 2-flop sync, per-bit debounce, per-group boolean reduction to LEDs, change pulse/counter.
// Define SLU_DEBOUNCE_BYPASS_EN to omit the debounce counters (stable follows the synchronised input).
module switch_logic_unit #(
  parameter int unsigned NUM_SW          = 16,
  parameter int unsigned GROUP_W         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 8
) (
  input  logic                        CLOCK_50_I,
  input  logic                        RESETN_I,
  input  logic [NUM_SW-1:0]           SWITCH_I,
  input  logic [2:0]                  MODE_I,
  input  logic                        MODE_LOAD_I,
  output logic [NUM_SW-1:0]           LED_RED_O,
  output logic [NUM_SW/GROUP_W-1:0]   LED_GREEN_O,
  output logic                        CHANGE_O,
  output logic [CNT_W-1:0]            CHANGE_CNT_O
);

  localparam int unsigned NUM_GRP = NUM_SW / GROUP_W;

  typedef enum logic [2:0] {
    MODE_AND  = 3'd0,
    MODE_OR   = 3'd1,
    MODE_XOR  = 3'd2,
    MODE_NAND = 3'd3,
    MODE_NOR  = 3'd4,
    MODE_XNOR = 3'd5,
    MODE_MAJ  = 3'd6,
    MODE_RSVD = 3'd7
  } mode_e;

  logic [NUM_SW-1:0]  sync1, sync2;
  logic [NUM_SW-1:0]  stable, stable_d1;
  logic [NUM_GRP-1:0] green_d;
  logic [GROUP_W-1:0] grp;
  int unsigned        ones;
  mode_e              mode_q;

  always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= SWITCH_I;
      sync2 <= sync1;
    end
  end

`ifdef SLU_DEBOUNCE_BYPASS_EN
  always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
    if (!RESETN_I) stable <= '0;
    else           stable <= sync2;
  end
`else
  localparam int unsigned    DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] db_cnt [NUM_SW];

  // Counter measures how long sync has disagreed with stable; any agreement restarts it.
  always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      stable <= '0;
      for (int unsigned i = 0; i < NUM_SW; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SW; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end
`endif

  assign LED_RED_O = stable;

  always_comb begin
    green_d = '0;
    grp     = '0;
    ones    = 0;
    for (int unsigned g = 0; g < NUM_GRP; g++) begin
      grp  = stable[g*GROUP_W +: GROUP_W];
      ones = 0;
      for (int unsigned b = 0; b < GROUP_W; b++) ones += 32'(grp[b]);
      case (mode_q)
        MODE_AND:  green_d[g] = &grp;
        MODE_OR:   green_d[g] = |grp;
        MODE_XOR:  green_d[g] = ^grp;
        MODE_NAND: green_d[g] = ~&grp;
        MODE_NOR:  green_d[g] = ~|grp;
        MODE_XNOR: green_d[g] = ~^grp;
        MODE_MAJ:  green_d[g] = (ones > GROUP_W / 2);
        default:   green_d[g] = 1'b0;
      endcase
    end
  end

  // stable_d1 holds the pre-flip value, so the pulse lands with the first updated LED_GREEN_O.
  always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      mode_q       <= MODE_AND;
      stable_d1    <= '0;
      LED_GREEN_O  <= '0;
      CHANGE_O     <= 1'b0;
      CHANGE_CNT_O <= '0;
    end else begin
      if (MODE_LOAD_I) mode_q <= mode_e'(MODE_I);
      stable_d1   <= stable;
      LED_GREEN_O <= green_d;
      CHANGE_O    <= |(stable ^ stable_d1);
      if (|(stable ^ stable_d1)) CHANGE_CNT_O <= CHANGE_CNT_O + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_switch_logic_unit.sv
// Bench for switch_logic_unit: sliding-window debounce model checked every cycle, plus directed literals.
module tb_switch_logic_unit;

  localparam int D = 4;
`ifdef SLU_DEBOUNCE_BYPASS_EN
  localparam int LAT        = 3;
  localparam int GLITCH_LEN = 1;
  localparam int GLITCH_CNT = 2;
`else
  localparam int LAT        = D + 2;
  localparam int GLITCH_LEN = 3;
  localparam int GLITCH_CNT = 0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] sw;
  logic [2:0]  mode_in;
  logic        mode_load;
  logic [15:0] led_red;
  logic [3:0]  led_green;
  logic        change;
  logic [7:0]  change_cnt;

  int tests = 0;
  int fails = 0;
  int pulse_cnt = 0;
  bit check_en = 1'b1;

  switch_logic_unit #(
    .NUM_SW(16),
    .GROUP_W(4),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(8)
  ) dut (
    .CLOCK_50_I  (clk),
    .RESETN_I    (rstn),
    .SWITCH_I    (sw),
    .MODE_I      (mode_in),
    .MODE_LOAD_I (mode_load),
    .LED_RED_O   (led_red),
    .LED_GREEN_O (led_green),
    .CHANGE_O    (change),
    .CHANGE_CNT_O(change_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: smp[0] is the latest sampled switch word, smp[k] is k edges older.
  logic [15:0] smp [0:D];
  logic [15:0] m_stable, m_prev, m_green16;
  logic [3:0]  m_green;
  logic        m_change;
  logic [7:0]  m_cnt;
  logic [2:0]  m_mode;

  function automatic logic [3:0] reduce(input logic [15:0] s, input logic [2:0] m);
    logic [3:0] r;
    int n;
    r = '0;
    for (int g = 0; g < 4; g++) begin
      n = $countones(s[g*4 +: 4]);
      case (m)
        3'd0: r[g] = (n == 4);
        3'd1: r[g] = (n > 0);
        3'd2: r[g] = (n % 2 == 1);
        3'd3: r[g] = (n != 4);
        3'd4: r[g] = (n == 0);
        3'd5: r[g] = (n % 2 == 0);
        3'd6: r[g] = (n > 2);
        default: r[g] = 1'b0;
      endcase
    end
    return r;
  endfunction

  initial begin
    logic [15:0] ns;
    bit all_diff;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        for (int k = 0; k <= D; k++) smp[k] = '0;
        m_stable = '0; m_prev = '0; m_green = '0; m_change = 1'b0; m_cnt = '0; m_mode = '0;
      end else begin
        ns = m_stable;
`ifdef SLU_DEBOUNCE_BYPASS_EN
        ns = smp[1];
`else
        // A bit flips once the last D synchronised samples all disagree with it.
        for (int b = 0; b < 16; b++) begin
          all_diff = 1'b1;
          for (int k = 1; k <= D; k++) if (smp[k][b] == m_stable[b]) all_diff = 1'b0;
          if (all_diff) ns[b] = ~m_stable[b];
        end
`endif
        m_change = (m_stable != m_prev);
        if (m_change) m_cnt = m_cnt + 8'd1;
        m_prev  = m_stable;
        m_green = reduce(m_stable, m_mode);
        m_stable = ns;
        if (mode_load) m_mode = mode_in;
        for (int k = D; k >= 1; k--) smp[k] = smp[k-1];
        smp[0] = sw;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rstn && check_en) begin
        chk("model_red",    32'(led_red),    32'(m_stable));
        chk("model_green",  32'(led_green),  32'(m_green));
        chk("model_change", 32'(change),     32'(m_change));
        chk("model_cnt",    32'(change_cnt), 32'(m_cnt));
      end
      if (rstn && change) pulse_cnt++;
    end
  end

  task automatic drive_sw(input logic [15:0] v);
    @(negedge clk);
    sw = v;
  endtask

  task automatic load_mode(input logic [2:0] m);
    @(negedge clk);
    mode_in = m; mode_load = 1'b1;
    @(negedge clk);
    mode_load = 1'b0;
  endtask

  task automatic edge_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] v);
    @(negedge clk);
    sw = v; rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; sw = '0; mode_in = '0; mode_load = 1'b0;
    #23;
    @(negedge clk);
    rstn = 1'b1;
    edge_wait(3);

    // Short glitch on bit 0.
    drive_sw(16'h0001);
    repeat (GLITCH_LEN) @(negedge clk);
    sw = 16'h0000;
    edge_wait(12);
    chk("glitch_red", 32'(led_red), 32'h0);
    chk("glitch_cnt", 32'(change_cnt), 32'(GLITCH_CNT));

    // 0x000F held with mode AND.
    drive_sw(16'h000F);
    for (int e = 1; e <= LAT + 1; e++) begin
      edge_wait(1);
      if (e == LAT - 1) chk("hold_red_early", 32'(led_red), 32'h0);
      if (e == LAT)     chk("hold_red", 32'(led_red), 32'h000F);
      if (e == LAT + 1) begin
        chk("hold_green", 32'(led_green), 32'b0001);
        chk("hold_change", 32'(change), 32'h1);
        chk("hold_cnt", 32'(change_cnt), 32'(GLITCH_CNT + 1));
      end
    end

    // Mode load NAND.
    load_mode(3'd3);
    edge_wait(2);
    chk("nand_green", 32'(led_green), 32'b1110);
    chk("nand_nochange", 32'(change), 32'h0);

    // Majority and reserved.
    drive_sw(16'h7310);
    edge_wait(10);
    load_mode(3'd6);
    edge_wait(3);
    chk("maj_green", 32'(led_green), 32'b1000);
    load_mode(3'd7);
    edge_wait(3);
    chk("rsvd_green", 32'(led_green), 32'b0000);

    // Mid-cycle reset during partial debounce of 0xFFFF.
    drive_sw(16'hFFFF);
    @(posedge clk); @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("rst_red", 32'(led_red), 32'h0);
    chk("rst_green", 32'(led_green), 32'h0);
    chk("rst_change", 32'(change), 32'h0);
    chk("rst_cnt", 32'(change_cnt), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    for (int e = 1; e <= LAT + 1; e++) begin
      edge_wait(1);
      if (e == LAT - 1) chk("rel_red_early", 32'(led_red), 32'h0);
      if (e == LAT)     chk("rel_red", 32'(led_red), 32'hFFFF);
      if (e == LAT + 1) chk("rel_cnt", 32'(change_cnt), 32'h1);
    end

    // Randomized phase: sparse bit flips and mode loads.
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) sw = sw ^ (16'h1 << $urandom_range(0, 15));
      mode_in   = 3'($urandom_range(0, 7));
      mode_load = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    mode_load = 1'b0;
    edge_wait(10);

    // 257 slow toggles of bit 5 wrap the 8-bit counter to 1.
    do_reset(16'h0000);
    edge_wait(2);
    @(negedge clk);
    pulse_cnt = 0;
    for (int t = 0; t < 257; t++) begin
      drive_sw(sw ^ 16'h0020);
      repeat (D + 4) @(posedge clk);
    end
    edge_wait(D + 6);
    chk("toggle_pulses", 32'(pulse_cnt), 32'd257);
    chk("toggle_cnt_wrap", 32'(change_cnt), 32'h1);
    chk("toggle_red", 32'(led_red), 32'h0020);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
